ysyx_22050019_mdu_ctrl: RTL and testbench

Sequencer for the M-extension datapath. It accepts one multiply, divide or remainder operation from decode and dispatches it to a shared external multiplier or iterative divider through valid/ready handshakes. It stalls the pipeline while that operation is in flight and applies the RISC-V divide-by-zero, signed-overflow and word-result rules. It sits between IDU (which supplies the one-hot M-op select and operands) and EXU writeback.

---
 rtl/ysyx_22050019_mdu_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ysyx_22050019_mdu_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050019_mdu_ctrl.sv
// M-extension sequencer: accepts one mul/div/rem op, dispatches it to the shared
// multiplier or divider over valid/ready, and resolves RISC-V divide corner cases locally.
module ysyx_22050019_mdu_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [9:0]      req_sel,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  output logic            req_ready,
  input  logic            flush,
  output logic            stall,
  output logic            mul_valid,
  input  logic            mul_ready,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  input  logic            mul_out_valid,
  input  logic [XLEN-1:0] mul_result,
  output logic            div_valid,
  input  logic            div_ready,
  output logic            div_signed,
  output logic            div_word,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder,
  output logic            eng_flush,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_MUL,
    S_WAIT_MUL,
    S_ISSUE_DIV,
    S_WAIT_DIV,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_mul_valid;
  logic              r_div_valid;
  logic              r_div_signed;
  logic              r_div_word;
  logic [XLEN-1:0]   r_mul_a;
  logic [XLEN-1:0]   r_mul_b;
  logic [XLEN-1:0]   r_div_dividend;
  logic [XLEN-1:0]   r_div_divisor;
  logic              r_eng_flush;
  logic              r_resp_valid;
  logic [XLEN-1:0]   r_resp_data;
  logic              r_word;
  logic              r_rem;

  logic              w_onehot;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_word;
  logic              w_signed;
  logic              w_ext_signed;
  logic              w_rem;
  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_b;
  logic [XLEN-1:0]   w_min;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_spec_res;
  logic              w_busy;

  function automatic logic [XLEN-1:0] f_fix(input logic word, input logic [XLEN-1:0] v);
    return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Select layout {mul_32, mul, div_32, divu_32, divu_64, div_64, rem_32, remu_32, remu_64, rem_64}
  always_comb begin
    w_onehot     = (req_sel != '0) && ((req_sel & (req_sel - 10'd1)) == '0);
    w_is_mul     = req_sel[9] | req_sel[8];
    w_is_div     = |req_sel[7:0];
    w_word       = req_sel[9] | req_sel[7] | req_sel[6] | req_sel[3] | req_sel[2];
    w_signed     = req_sel[7] | req_sel[4] | req_sel[3] | req_sel[0];
    w_rem        = |req_sel[3:0];
    w_ext_signed = !(req_sel[6] | req_sel[2]);
    w_a = req_src1;
    w_b = req_src2;
    if (w_word) begin
      w_a = w_ext_signed ? {{(XLEN-32){req_src1[31]}}, req_src1[31:0]}
                         : {{(XLEN-32){1'b0}}, req_src1[31:0]};
      w_b = w_ext_signed ? {{(XLEN-32){req_src2[31]}}, req_src2[31:0]}
                         : {{(XLEN-32){1'b0}}, req_src2[31:0]};
    end
    // Word operands are already sign-extended, so the word minimum is compared at 64 bits
    w_min      = w_word ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
    w_div0     = w_is_div && (w_b == '0);
    w_ovf      = w_is_div && w_signed && (w_a == w_min) && (w_b == '1);
    w_spec_res = w_div0 ? (w_rem ? w_a : '1) : (w_rem ? '0 : w_a);
    w_busy     = (r_state == S_ISSUE_MUL) || (r_state == S_WAIT_MUL) ||
                 (r_state == S_ISSUE_DIV) || (r_state == S_WAIT_DIV);
    req_ready  = (r_state == S_IDLE) && !flush;
    w_accept   = req_valid && req_ready && w_onehot;
    stall      = ((r_state == S_IDLE) && req_valid && !flush && w_onehot) || w_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_mul_valid    <= 1'b0;
      r_div_valid    <= 1'b0;
      r_div_signed   <= 1'b0;
      r_div_word     <= 1'b0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_eng_flush    <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_data    <= '0;
      r_word         <= 1'b0;
      r_rem          <= 1'b0;
    end else begin
      r_eng_flush  <= 1'b0;
      r_resp_valid <= 1'b0;
      if (flush) begin
        r_state     <= S_IDLE;
        r_mul_valid <= 1'b0;
        r_div_valid <= 1'b0;
        r_eng_flush <= w_busy;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_word <= w_word;
              r_rem  <= w_rem;
              if (w_div0 || w_ovf) begin
                r_resp_data  <= f_fix(w_word, w_spec_res);
                r_resp_valid <= 1'b1;
                r_state      <= S_DONE;
              end else if (w_is_mul) begin
                r_mul_a     <= w_a;
                r_mul_b     <= w_b;
                r_mul_valid <= 1'b1;
                r_state     <= S_ISSUE_MUL;
              end else begin
                r_div_dividend <= w_a;
                r_div_divisor  <= w_b;
                r_div_signed   <= w_signed;
                r_div_word     <= w_word;
                r_div_valid    <= 1'b1;
                r_state        <= S_ISSUE_DIV;
              end
            end
          end
          S_ISSUE_MUL: if (mul_ready) begin
            r_mul_valid <= 1'b0;
            r_state     <= S_WAIT_MUL;
          end
          S_WAIT_MUL: if (mul_out_valid) begin
            r_resp_data  <= f_fix(r_word, mul_result);
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end
          S_ISSUE_DIV: if (div_ready) begin
            r_div_valid <= 1'b0;
            r_state     <= S_WAIT_DIV;
          end
          S_WAIT_DIV: if (div_out_valid) begin
            r_resp_data  <= f_fix(r_word, r_rem ? div_remainder : div_quotient);
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mul_valid    = r_mul_valid;
  assign mul_a        = r_mul_a;
  assign mul_b        = r_mul_b;
  assign div_valid    = r_div_valid;
  assign div_signed   = r_div_signed;
  assign div_word     = r_div_word;
  assign div_dividend = r_div_dividend;
  assign div_divisor  = r_div_divisor;
  assign eng_flush    = r_eng_flush;
  assign resp_valid   = r_resp_valid;
  assign resp_data    = r_resp_data;

endmodule

// File: tb/tb_ysyx_22050019_mdu_ctrl.sv
// Directed bench for the M-extension sequencer: engine paths, corner cases, flush and reset.
module tb_ysyx_22050019_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [9:0]  req_sel;
  logic [63:0] req_src1, req_src2;
  logic        req_ready, flush, stall;
  logic        mul_valid, mul_ready;
  logic [63:0] mul_a, mul_b;
  logic        mul_out_valid;
  logic [63:0] mul_result;
  logic        div_valid, div_ready, div_signed, div_word;
  logic [63:0] div_dividend, div_divisor;
  logic        div_out_valid;
  logic [63:0] div_quotient, div_remainder;
  logic        eng_flush, resp_valid;
  logic [63:0] resp_data;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  localparam logic [9:0] SEL_MUL32  = 10'b10_0000_0000;
  localparam logic [9:0] SEL_MUL    = 10'b01_0000_0000;
  localparam logic [9:0] SEL_DIV32  = 10'b00_1000_0000;
  localparam logic [9:0] SEL_DIV64  = 10'b00_0001_0000;
  localparam logic [9:0] SEL_REM32  = 10'b00_0000_1000;
  localparam logic [9:0] SEL_REMU32 = 10'b00_0000_0100;
  localparam logic [9:0] SEL_REM64  = 10'b00_0000_0001;

  always #5 clk = ~clk;

  ysyx_22050019_mdu_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
    .req_src1(req_src1), .req_src2(req_src2), .req_ready(req_ready),
    .flush(flush), .stall(stall),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out_valid(mul_out_valid), .mul_result(mul_result),
    .div_valid(div_valid), .div_ready(div_ready), .div_signed(div_signed),
    .div_word(div_word), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_out_valid(div_out_valid), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .eng_flush(eng_flush),
    .resp_valid(resp_valid), .resp_data(resp_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge, inputs then settle before checks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [9:0] sel, input logic [63:0] a, input logic [63:0] b);
    req_valid = 1'b1;
    req_sel   = sel;
    req_src1  = a;
    req_src2  = b;
    #1;
  endtask

  // Special-case op: no engine handshake, response the cycle after accept
  task automatic special(input string tag, input logic [9:0] sel, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
    req(sel, a, b);
    chk({tag, "_stall_T"}, stall, 1'b1);
    tick();
    req_valid = 1'b0;
    #1;
    chk({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk({tag, "_resp_data"}, resp_data, exp);
    chk({tag, "_no_div_valid"}, div_valid, 1'b0);
    chk({tag, "_stall_done"}, stall, 1'b0);
    tick();
    chk({tag, "_resp_drop"}, resp_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_sel = '0; req_src1 = '0; req_src2 = '0;
    flush = 1'b0; mul_ready = 1'b0; mul_out_valid = 1'b0; mul_result = '0;
    div_ready = 1'b0; div_out_valid = 1'b0; div_quotient = '0; div_remainder = '0;
    tick();
    tick();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mul_valid", mul_valid, 1'b0);
    chk("rst_div_valid", div_valid, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_eng_flush", eng_flush, 1'b0);
    rst = 1'b0;
    tick();

    // mul 3*5 on the fastest engine path
    req(SEL_MUL, 64'd3, 64'd5);
    chk("mul_stall_T", stall, 1'b1);
    tick();
    req_valid = 1'b0; mul_ready = 1'b1; #1;
    chk("mul_valid_T1", mul_valid, 1'b1);
    chk("mul_a", mul_a, 64'd3);
    chk("mul_b", mul_b, 64'd5);
    chk("mul_stall_T1", stall, 1'b1);
    tick();
    mul_ready = 1'b0; mul_out_valid = 1'b1; mul_result = 64'd15; #1;
    chk("mul_valid_T2", mul_valid, 1'b0);
    chk("mul_stall_T2", stall, 1'b1);
    chk("mul_no_resp_T2", resp_valid, 1'b0);
    tick();
    mul_out_valid = 1'b0; #1;
    chk("mul_resp_valid", resp_valid, 1'b1);
    chk("mul_resp_data", resp_data, 64'd15);
    chk("mul_stall_done", stall, 1'b0);
    chk("mul_ready_done", req_ready, 1'b0);
    tick();
    chk("mul_resp_drop", resp_valid, 1'b0);
    chk("mul_idle_ready", req_ready, 1'b1);

    special("div64_by0", SEL_DIV64, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    special("rem64_by0", SEL_REM64, 64'd7, 64'd0, 64'd7);
    special("div32_ovf", SEL_DIV32, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000);
    special("rem32_ovf", SEL_REM32, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0);

    // remu_32: zero-extended operands, result sign-extended from bit 31
    req(SEL_REMU32, 64'h0000_0001_0000_0007, 64'h0000_0000_0000_0003);
    tick();
    req_valid = 1'b0; div_ready = 1'b1; #1;
    chk("remu32_div_valid", div_valid, 1'b1);
    chk("remu32_dividend", div_dividend, 64'd7);
    chk("remu32_divisor", div_divisor, 64'd3);
    chk("remu32_word", div_word, 1'b1);
    chk("remu32_signed", div_signed, 1'b0);
    tick();
    div_ready = 1'b0; div_out_valid = 1'b1;
    div_quotient = 64'h55; div_remainder = 64'h0000_0000_8000_0001; #1;
    tick();
    div_out_valid = 1'b0; #1;
    chk("remu32_resp_valid", resp_valid, 1'b1);
    chk("remu32_resp_data", resp_data, 64'hFFFF_FFFF_8000_0001);
    tick();

    // mul_32: sign-extended operands and word result
    req(SEL_MUL32, 64'h0000_0000_FFFF_FFFF, 64'd2);
    tick();
    req_valid = 1'b0; mul_ready = 1'b1; #1;
    chk("mul32_a", mul_a, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mul32_b", mul_b, 64'd2);
    tick();
    mul_ready = 1'b0; mul_out_valid = 1'b1; mul_result = 64'h1_8000_0000; #1;
    tick();
    mul_out_valid = 1'b0; #1;
    chk("mul32_resp_data", resp_data, 64'hFFFF_FFFF_8000_0000);
    tick();

    // div_64 with div_ready low for three cycles, then flush in WAIT_DIV
    req(SEL_DIV64, 64'd100, 64'd7);
    tick();
    req_valid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("div_hold_valid", div_valid, 1'b1);
      chk("div_hold_dividend", div_dividend, 64'd100);
      chk("div_hold_divisor", div_divisor, 64'd7);
      chk("div_hold_stall", stall, 1'b1);
      tick();
    end
    chk("div_signed", div_signed, 1'b1);
    chk("div_word", div_word, 1'b0);
    div_ready = 1'b1; #1;
    tick();
    div_ready = 1'b0; #1;
    chk("div_wait_valid", div_valid, 1'b0);
    chk("div_wait_stall", stall, 1'b1);
    flush = 1'b1; div_out_valid = 1'b1; div_quotient = 64'd14; #1;
    chk("div_flush_ready", req_ready, 1'b0);
    tick();
    flush = 1'b0; div_out_valid = 1'b0; #1;
    chk("flush_eng_pulse", eng_flush, 1'b1);
    chk("flush_no_resp", resp_valid, 1'b0);
    chk("flush_idle_ready", req_ready, 1'b1);
    chk("flush_stall", stall, 1'b0);
    tick();
    chk("flush_eng_once", eng_flush, 1'b0);
    chk("flush_no_resp_late", resp_valid, 1'b0);

    // Non-one-hot select is ignored
    req(10'b00_0000_0011, 64'd1, 64'd1);
    chk("bad_sel_stall", stall, 1'b0);
    tick();
    chk("bad_sel_mul", mul_valid, 1'b0);
    chk("bad_sel_div", div_valid, 1'b0);
    tick();
    chk("bad_sel_resp", resp_valid, 1'b0);
    req_valid = 1'b0;

    // Flush in IDLE blocks accept
    req(SEL_MUL, 64'd1, 64'd1);
    flush = 1'b1; #1;
    chk("idle_flush_ready", req_ready, 1'b0);
    chk("idle_flush_stall", stall, 1'b0);
    tick();
    req_valid = 1'b0; flush = 1'b0; #1;
    chk("idle_flush_no_issue", mul_valid, 1'b0);
    chk("idle_flush_no_eng", eng_flush, 1'b0);
    tick();

    // Back-to-back muls with req_valid held
    req(SEL_MUL, 64'd6, 64'd7);
    tick();
    mul_ready = 1'b1; #1;
    tick();
    mul_ready = 1'b0; mul_out_valid = 1'b1; mul_result = 64'd42; #1;
    tick();
    mul_out_valid = 1'b0; req_src1 = 64'd2; req_src2 = 64'd9; #1;
    chk("b2b_resp1", resp_data, 64'd42);
    chk("b2b_done_ready", req_ready, 1'b0);
    chk("b2b_done_stall", stall, 1'b0);
    tick();
    chk("b2b_idle_ready", req_ready, 1'b1);
    chk("b2b_idle_stall", stall, 1'b1);
    chk("b2b_idle_mulv", mul_valid, 1'b0);
    tick();
    req_valid = 1'b0; mul_ready = 1'b1; #1;
    chk("b2b_second_issue", mul_valid, 1'b1);
    chk("b2b_second_a", mul_a, 64'd2);
    tick();
    mul_ready = 1'b0; #1;
    chk("b2b_wait_stall", stall, 1'b1);

    // Asynchronous reset mid-WAIT_MUL, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("arst_stall", stall, 1'b0);
    chk("arst_mul_valid", mul_valid, 1'b0);
    chk("arst_mul_a", mul_a, 64'd0);
    chk("arst_resp_data", resp_data, 64'd0);
    chk("arst_eng_flush", eng_flush, 1'b0);
    chk("arst_ready", req_ready, 1'b1);
    #1 rst = 1'b0;
    tick();
    chk("arst_after_resp", resp_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
